// File: rtl/pam4_tx_framer_if.sv
// Command/data bundle between a PAM4 frame source controller and pam4_tx_framer.
// master drives the request side, slave (the framer) drives the symbol side.
interface pam4_tx_framer_if #(
  parameter int PARALLELISM = 8,
  parameter int NB_OUT      = 18,
  parameter int NB_LEN      = 16
);
  logic                          i_en;
  logic                          i_start;
  logic                          i_stop;
  logic                          i_mode;
  logic [NB_LEN-1:0]             i_frame_len;
  logic [2*PARALLELISM-1:0]      i_data;
  logic                          o_data_req;
  logic [PARALLELISM*NB_OUT-1:0] o_sample;
  logic                          o_valid;
  logic                          o_preamble;
  logic                          o_done;

  modport master (
    output i_en, i_start, i_stop, i_mode, i_frame_len, i_data,
    input  o_data_req, o_sample, o_valid, o_preamble, o_done
  );

  modport slave (
    input  i_en, i_start, i_stop, i_mode, i_frame_len, i_data,
    output o_data_req, o_sample, o_valid, o_preamble, o_done
  );
endinterface

// File: rtl/pam4_tx_framer.sv
// PAM4 transmit framer: IDLE -> PREAMBLE -> PAYLOAD, emitting PARALLELISM Gray-mapped
// fixed-point symbols per clock (lane 0 oldest) from PRBS15 or external bits.
module pam4_tx_framer #(
  parameter int          PARALLELISM  = 8,
  parameter int          NB_OUT       = 18,
  parameter int          NBF_OUT      = 15,
  parameter int          LVL_OUTER    = 32768,
  parameter int          LVL_INNER    = 10923,
  parameter int          PREAMBLE_LEN = 64,
  parameter int          NB_LEN       = 16,
  parameter logic [14:0] PRBS_SEED    = 15'h7FFF
) (
  input logic              i_clock,
  input logic              i_reset,
  pam4_tx_framer_if.slave  bus
);

  localparam int NB_WORD = PARALLELISM * NB_OUT;
  localparam int NB_BITS = 2 * PARALLELISM;
  localparam int PRE_W   = $clog2(PREAMBLE_LEN + 1);
  localparam int CNT_W   = (NB_LEN > PRE_W) ? NB_LEN : PRE_W;

  localparam logic signed [NB_OUT-1:0] LVL_O = NB_OUT'(LVL_OUTER);
  localparam logic signed [NB_OUT-1:0] LVL_I = NB_OUT'(LVL_INNER);

  if (PRBS_SEED == 15'd0) begin : g_bad_seed
    $error("PRBS_SEED must be nonzero");
  end
  if (NBF_OUT >= NB_OUT || PREAMBLE_LEN < 1) begin : g_bad_format
    $error("invalid NBF_OUT or PREAMBLE_LEN");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2
  } state_t;

  function automatic logic signed [NB_OUT-1:0] gray_level(input logic [1:0] sym);
    logic signed [NB_OUT-1:0] lvl;
    unique case (sym)
      2'b00:   lvl = -LVL_O;
      2'b01:   lvl = -LVL_I;
      2'b11:   lvl = LVL_I;
      default: lvl = LVL_O;
    endcase
    return lvl;
  endfunction

  function automatic logic [NB_WORD-1:0] map_word(input logic [NB_BITS-1:0] bits);
    logic [NB_WORD-1:0] w;
    w = '0;
    for (int k = 0; k < PARALLELISM; k++) begin
      w[k*NB_OUT +: NB_OUT] = gray_level(bits[2*k +: 2]);
    end
    return w;
  endfunction

  function automatic logic [NB_WORD-1:0] preamble_word();
    logic [NB_WORD-1:0] w;
    w = '0;
    for (int k = 0; k < PARALLELISM; k++) begin
      w[k*NB_OUT +: NB_OUT] = (k % 2 == 0) ? LVL_O : -LVL_O;
    end
    return w;
  endfunction

  // Bit i of the run lands at position i^1 so that even bits are lane MSBs,
  // giving the same packing as i_data.
  function automatic logic [NB_BITS+14:0] prbs_advance(input logic [14:0] seed);
    logic [14:0]        st;
    logic [NB_BITS-1:0] b;
    logic               nb;
    st = seed;
    b  = '0;
    for (int i = 0; i < NB_BITS; i++) begin
      nb       = st[14] ^ st[13];
      st       = {st[13:0], nb};
      b[i ^ 1] = nb;
    end
    return {b, st};
  endfunction

  localparam logic [NB_WORD-1:0] PRE_WORD = preamble_word();

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [14:0]        prbs_q, prbs_d;
  logic               mode_q, mode_d;
  logic [NB_LEN-1:0]  len_q, len_d;
  logic               pend_q, pend_d;
  logic [NB_WORD-1:0] sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               pre_q, pre_d;
  logic               done_q, done_d;

  logic [NB_BITS-1:0] prbs_bits;
  logic [14:0]        prbs_next;
  logic               last_pre;
  logic               last_pay;

  assign {prbs_bits, prbs_next} = prbs_advance(prbs_q);
  assign last_pre = (cnt_q == CNT_W'(PREAMBLE_LEN - 1));
  assign last_pay = (len_q != '0) && (cnt_q == CNT_W'(len_q) - CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prbs_d   = prbs_q;
    mode_d   = mode_q;
    len_d    = len_q;
    pend_d   = pend_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    pre_d    = pre_q;
    done_d   = done_q;

    if (bus.i_en) begin
      // Completion of a fixed-length frame is flagged one cycle after its last word.
      valid_d  = 1'b0;
      pre_d    = 1'b0;
      sample_d = '0;
      done_d   = pend_q;
      pend_d   = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (bus.i_start && !bus.i_stop) begin
            state_d = ST_PREAMBLE;
            cnt_d   = '0;
            prbs_d  = PRBS_SEED;
            mode_d  = bus.i_mode;
            len_d   = bus.i_frame_len;
          end
        end
        ST_PREAMBLE: begin
          if (bus.i_stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            valid_d  = 1'b1;
            pre_d    = 1'b1;
            sample_d = PRE_WORD;
            if (last_pre) begin
              state_d = ST_PAYLOAD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_PAYLOAD: begin
          if (bus.i_stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            valid_d  = 1'b1;
            sample_d = map_word(mode_q ? bus.i_data : prbs_bits);
            prbs_d   = prbs_next;
            if (last_pay) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              pend_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prbs_q   <= PRBS_SEED;
      mode_q   <= 1'b0;
      len_q    <= '0;
      pend_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      pre_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prbs_q   <= prbs_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      pend_q   <= pend_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      pre_q    <= pre_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_data_req = (state_q == ST_PAYLOAD) && bus.i_en && mode_q;
  assign bus.o_sample   = sample_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_preamble = pre_q;
  assign bus.o_done     = done_q;

endmodule

// File: tb/tb_pam4_tx_framer.sv
// Bench for pam4_tx_framer: directed frames plus randomized frames, every cycle
// compared against a frame-level reference model built on a precomputed PRBS15 sequence.
module tb_pam4_tx_framer;
  localparam int P       = 8;
  localparam int NBO     = 18;
  localparam int NBL     = 16;
  localparam int PRE_LEN = 64;
  localparam int WW      = P * NBO;

  logic clk;
  logic rst;

  pam4_tx_framer_if #(.PARALLELISM(P), .NB_OUT(NBO), .NB_LEN(NBL)) bus ();

  pam4_tx_framer #(
    .PARALLELISM(P), .NB_OUT(NBO), .NBF_OUT(15), .LVL_OUTER(32768), .LVL_INNER(10923),
    .PREAMBLE_LEN(PRE_LEN), .NB_LEN(NBL), .PRBS_SEED(15'h7FFF)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: x[0..14] is the all-ones seed, x[n] = x[n-15] ^ x[n-14] thereafter.
  bit prbs_seq [0:8191];

  int          m_phase    = 0;  // 0 idle, 1 preamble, 2 payload
  int          m_pre_done = 0;
  int          m_pay_done = 0;
  int          m_len      = 0;
  int          m_ptr      = 0;
  bit          m_mode     = 1'b0;
  bit          m_pend     = 1'b0;
  logic          e_valid  = 1'b0;
  logic          e_pre    = 1'b0;
  logic          e_done   = 1'b0;
  logic [WW-1:0] e_sample = '0;

  int            n_checks = 0;
  int            n_pass   = 0;
  bit            run      = 1'b0;
  int            pin_kind = 0;
  logic [WW-1:0] pin_word = '0;
  int            pin_cnt  = 0;
  string         pin_name = "";

  function automatic int level(input bit msb, input bit lsb);
    case ({msb, lsb})
      2'b00:   return -32768;
      2'b01:   return -10923;
      2'b11:   return 10923;
      default: return 32768;
    endcase
  endfunction

  function automatic logic [WW-1:0] lanes8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [WW-1:0] w;
    int v [8];
    v = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int k = 0; k < P; k++) w[k*NBO +: NBO] = NBO'(v[k]);
    return w;
  endfunction

  function automatic logic [WW-1:0] rep4(input int a, b, c, d);
    return lanes8(a, b, c, d, a, b, c, d);
  endfunction

  task automatic model_step();
    bit            nd;
    bit            msb, lsb;
    logic [WW-1:0] w;
    if (!rst) begin
      m_phase = 0; m_pend = 1'b0;
      e_valid = 1'b0; e_pre = 1'b0; e_done = 1'b0; e_sample = '0;
    end else if (bus.i_en) begin
      nd = m_pend; m_pend = 1'b0;
      e_valid = 1'b0; e_pre = 1'b0; e_sample = '0;
      case (m_phase)
        0: if (bus.i_start && !bus.i_stop) begin
             m_phase = 1; m_pre_done = 0; m_len = int'(bus.i_frame_len);
             m_mode = bus.i_mode; m_ptr = 0;
           end
        1: if (bus.i_stop) begin
             m_phase = 0; nd = 1'b1;
           end else begin
             e_valid = 1'b1; e_pre = 1'b1;
             e_sample = rep4(32768, -32768, 32768, -32768);
             m_pre_done++;
             if (m_pre_done == PRE_LEN) begin m_phase = 2; m_pay_done = 0; end
           end
        default: if (bus.i_stop) begin
             m_phase = 0; nd = 1'b1;
           end else begin
             for (int k = 0; k < P; k++) begin
               if (m_mode) begin
                 msb = bus.i_data[2*k+1]; lsb = bus.i_data[2*k];
               end else begin
                 msb = prbs_seq[15 + m_ptr + 2*k]; lsb = prbs_seq[16 + m_ptr + 2*k];
               end
               w[k*NBO +: NBO] = NBO'(level(msb, lsb));
             end
             e_valid = 1'b1; e_sample = w;
             m_ptr += 2 * P; m_pay_done++;
             if (m_len != 0 && m_pay_done == m_len) begin m_phase = 0; m_pend = 1'b1; end
           end
      endcase
      e_done = nd;
    end
  endtask

  task automatic tick();
    pin_kind = 0;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pin(input int kind, input string name);
    pin_kind = kind;
    pin_name = name;
  endtask

  // Compare process: every cycle against the model, plus any pinned literal.
  initial begin : compare
    int  req_cnt;
    bit  e_req;
    req_cnt = 0;
    forever begin
      @(negedge clk);
      if (run) begin
        e_req = (m_phase == 2) && bus.i_en && m_mode;
        do_check("cycle",
          bus.o_valid === e_valid && bus.o_preamble === e_pre && bus.o_done === e_done &&
          bus.o_data_req === e_req && bus.o_sample === e_sample,
          $sformatf("v%b p%b d%b r%b %h", bus.o_valid, bus.o_preamble, bus.o_done, bus.o_data_req, bus.o_sample),
          $sformatf("v%b p%b d%b r%b %h", e_valid, e_pre, e_done, e_req, e_sample));
        case (pin_kind)
          1: begin
            do_check({pin_name, "_dut"}, bus.o_valid === 1'b1 && bus.o_sample === pin_word,
                     $sformatf("%h", bus.o_sample), $sformatf("%h", pin_word));
            do_check({pin_name, "_model"}, e_sample === pin_word,
                     $sformatf("%h", e_sample), $sformatf("%h", pin_word));
          end
          2: do_check(pin_name, bus.o_done === 1'b1 && bus.o_valid === 1'b0,
                      $sformatf("done=%b valid=%b", bus.o_done, bus.o_valid), "done=1 valid=0");
          3: do_check(pin_name, bus.o_data_req === 1'b1,
                      $sformatf("req=%b", bus.o_data_req), "req=1");
          4: do_check(pin_name, bus.o_valid === 1'b0 && bus.o_preamble === 1'b0 &&
                      bus.o_done === 1'b0 && bus.o_sample === '0,
                      $sformatf("v%b p%b d%b %h", bus.o_valid, bus.o_preamble, bus.o_done, bus.o_sample),
                      "all zero");
          5: begin
            do_check(pin_name, req_cnt == pin_cnt, $sformatf("%0d", req_cnt), $sformatf("%0d", pin_cnt));
            req_cnt = 0;
          end
          default: ;
        endcase
        if (bus.o_data_req === 1'b1) req_cnt++;
      end
    end
  end

  task automatic do_check(input string name, input bit ok, input string act, input string req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, required %s", name, act, req);
  endtask

  initial begin : driver
    int flen;
    int stop_at;
    for (int i = 0; i < 15; i++) prbs_seq[i] = 1'b1;
    for (int i = 15; i < 8192; i++) prbs_seq[i] = prbs_seq[i-15] ^ prbs_seq[i-14];

    rst = 1'b0;
    bus.i_en = 1'b1; bus.i_start = 1'b1; bus.i_stop = 1'b0; bus.i_mode = 1'b0;
    bus.i_frame_len = '0; bus.i_data = '0;

    // Reset held with start asserted
    tick(); run = 1'b1;
    tick(); tick(); pin(4, "reset_idle");

    // PRBS frame, L=4
    bus.i_frame_len = NBL'(4); bus.i_mode = 1'b0;
    tick(); rst = 1'b1;
    tick(); bus.i_start = 1'b0;
    tick(); pin_word = rep4(32768, -32768, 32768, -32768); pin(1, "preamble_word");
    repeat (63) tick();
    tick(); pin_word = lanes8(-32768, -32768, -32768, -32768, -32768, -32768, -32768, 32768);
    pin(1, "prbs_first_word");
    repeat (3) tick();
    tick(); pin(2, "done_len4");
    tick(); pin(4, "idle_after_len4");

    // External data, L=2
    bus.i_mode = 1'b1; bus.i_frame_len = NBL'(2); bus.i_start = 1'b1;
    tick(); bus.i_start = 1'b0;
    repeat (64) tick();
    bus.i_data = 16'h1B1B; pin(3, "req_high");
    tick(); pin_word = rep4(10923, 32768, -10923, -32768); pin(1, "ext_1b1b");
    bus.i_data = 16'hE4E4;
    tick(); pin_word = rep4(-32768, -10923, 32768, 10923); pin(1, "ext_e4e4");
    tick(); pin(2, "done_ext");
    tick(); pin_cnt = 2; pin(5, "req_count");

    // Continuous PRBS with an enable freeze, then stop
    bus.i_mode = 1'b0; bus.i_frame_len = '0; bus.i_start = 1'b1;
    tick(); bus.i_start = 1'b0;
    repeat (64 + 50) tick();
    bus.i_en = 1'b0;
    repeat (5) tick();
    bus.i_en = 1'b1;
    repeat (50) tick();
    bus.i_stop = 1'b1;
    tick(); bus.i_stop = 1'b0; pin(2, "stop_done");
    tick(); pin(4, "idle_after_stop");

    // Start and stop together in IDLE
    bus.i_start = 1'b1; bus.i_stop = 1'b1;
    tick(); tick();
    bus.i_start = 1'b0; bus.i_stop = 1'b0; pin(4, "start_stop_idle");

    // Reset in the middle of the preamble
    bus.i_start = 1'b1;
    tick(); bus.i_start = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    tick(); pin(4, "reset_mid_pre");
    rst = 1'b1;
    tick();

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      bus.i_mode = 1'($urandom_range(0, 1));
      flen = $urandom_range(0, 5);
      bus.i_frame_len = NBL'(flen);
      stop_at = (flen == 0 || $urandom_range(0, 3) == 0) ? $urandom_range(5, 90) : 1000;
      bus.i_start = 1'b1;
      tick();
      for (int c = 0; c < 400; c++) begin
        bus.i_data      = (2*P)'($urandom);
        bus.i_start     = ($urandom_range(0, 7) == 0);
        bus.i_frame_len = NBL'($urandom);
        if (c == stop_at) begin
          bus.i_stop = 1'b1; bus.i_en = 1'b1;
        end else begin
          bus.i_stop = 1'b0; bus.i_en = ($urandom_range(0, 5) != 0);
        end
        tick();
        if (m_phase == 0) break;
      end
      bus.i_stop = 1'b0; bus.i_start = 1'b0; bus.i_en = 1'b1;
      tick(); tick();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
